mux_4x1: RTL and testbench

- 4-to-1 selector: routes one of four data inputs (in1..in4) to out under a 2-bit select formed by {sel1, sel0}.
- Used as a generic datapath steering element in the 32-bit CPU, e.g. operand and writeback source selection.
- Output is registered on the single system clock by default; a parameter gives a purely combinational variant.

---
 rtl/mux_4x1_pkg.sv | 17 +
 rtl/mux_4x1_if.sv | 35 +++
 rtl/mux_4x1_core.sv | 27 ++
 rtl/mux_4x1.sv | 52 +++++
 tb/tb_mux_4x1.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mux_4x1_pkg.sv
// Shared select encoding for the 4-way datapath selectors.
// Other datapath muxes import this so every selector agrees on which code picks which input.
package mux_4x1_pkg;

    typedef enum logic [1:0] {
        SEL_IN1 = 2'b00,
        SEL_IN2 = 2'b01,
        SEL_IN3 = 2'b10,
        SEL_IN4 = 2'b11
    } sel_t;

    // sel1 is the MSB of the select code
    function automatic sel_t packSel(input logic i_sel1, input logic i_sel0);
        return sel_t'({i_sel1, i_sel0});
    endfunction

endpackage

// File: rtl/mux_4x1_if.sv
// Bundle of data inputs, select bits and result for the 4-to-1 selector.
// The master drives data and select; the slave (the selector) drives out.
interface mux_4x1_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic             sel1;
    logic             sel0;
    logic [WIDTH-1:0] out;

    modport master (
        output in1,
        output in2,
        output in3,
        output in4,
        output sel1,
        output sel0,
        input  out
    );

    modport slave (
        input  in1,
        input  in2,
        input  in3,
        input  in4,
        input  sel1,
        input  sel0,
        output out
    );

endinterface

// File: rtl/mux_4x1_core.sv
// Purely combinational WIDTH-bit 4-to-1 selector.
// Any select code outside the four legal values (X/Z in simulation) yields all-zeros.
module mux_4x1_core
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [WIDTH-1:0] i_in3,
    input  logic [WIDTH-1:0] i_in4,
    input  sel_t             i_sel,
    output logic [WIDTH-1:0] o_out
);

    always_comb begin
        o_out = '0;
        case (i_sel)
            SEL_IN1: o_out = i_in1;
            SEL_IN2: o_out = i_in2;
            SEL_IN3: o_out = i_in3;
            SEL_IN4: o_out = i_in4;
            default: o_out = '0;
        endcase
    end

endmodule

// File: rtl/mux_4x1.sv
// 4-to-1 datapath selector with an optional output register.
// REG_OUT=1 gives one cycle of latency with async clear; REG_OUT=0 is a bare combinational path.
module mux_4x1
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic      clk,
    input  logic      rst,
    mux_4x1_if.slave  bus
);

    sel_t             w_sel;
    logic [WIDTH-1:0] w_selected;

    assign w_sel = packSel(bus.sel1, bus.sel0);

    mux_4x1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_in1 (bus.in1),
        .i_in2 (bus.in2),
        .i_in3 (bus.in3),
        .i_in4 (bus.in4),
        .i_sel (w_sel),
        .o_out (w_selected)
    );

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [WIDTH-1:0] r_out;

            // Reset clears immediately; release takes effect at the next rising edge
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= '0;
                end else begin
                    r_out <= w_selected;
                end
            end

            assign bus.out = r_out;
        end else begin : g_comb
            logic w_unusedClkRst;

            assign w_unusedClkRst = clk ^ rst;
            assign bus.out        = w_selected;
        end
    endgenerate

endmodule

// File: tb/tb_mux_4x1.sv
// Directed, table-driven bench for mux_4x1: narrow and wide registered variants plus the combinational one.
// All three DUTs see the same vectors; the 1-bit DUTs get bit 0 of each 32-bit value.
module tb_mux_4x1;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] in3;
        logic [31:0] in4;
        logic [1:0]  sel;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prevExp;
    vec_t        vecs[9];

    mux_4x1_if #(.WIDTH(1))  ifNarrow ();
    mux_4x1_if #(.WIDTH(32)) ifWide ();
    mux_4x1_if #(.WIDTH(1))  ifComb ();

    mux_4x1 #(.WIDTH(1), .REG_OUT(1)) u_narrow (
        .clk (clk),
        .rst (rst),
        .bus (ifNarrow)
    );

    mux_4x1 #(.WIDTH(32), .REG_OUT(1)) u_wide (
        .clk (clk),
        .rst (rst),
        .bus (ifWide)
    );

    mux_4x1 #(.WIDTH(1), .REG_OUT(0)) u_comb (
        .clk (clk),
        .rst (rst),
        .bus (ifComb)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveVector(input vec_t v);
        ifWide.in1    = v.in1;
        ifWide.in2    = v.in2;
        ifWide.in3    = v.in3;
        ifWide.in4    = v.in4;
        ifWide.sel1   = v.sel[1];
        ifWide.sel0   = v.sel[0];
        ifNarrow.in1  = v.in1[0];
        ifNarrow.in2  = v.in2[0];
        ifNarrow.in3  = v.in3[0];
        ifNarrow.in4  = v.in4[0];
        ifNarrow.sel1 = v.sel[1];
        ifNarrow.sel0 = v.sel[0];
        ifComb.in1    = v.in1[0];
        ifComb.in2    = v.in2[0];
        ifComb.in3    = v.in3[0];
        ifComb.in4    = v.in4[0];
        ifComb.sel1   = v.sel[1];
        ifComb.sel0   = v.sel[0];
    endtask

    // Drive between edges, confirm registered outputs still hold the old value, then check one edge later
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        driveVector(v);
        #1;
        checkOutput($sformatf("comb_vec%0d", idx), {31'b0, ifComb.out}, {31'b0, v.exp[0]});
        checkOutput($sformatf("narrow_hold_vec%0d", idx), {31'b0, ifNarrow.out}, {31'b0, prevExp[0]});
        checkOutput($sformatf("wide_hold_vec%0d", idx), ifWide.out, prevExp);
        @(posedge clk);
        #1;
        checkOutput($sformatf("narrow_vec%0d", idx), {31'b0, ifNarrow.out}, {31'b0, v.exp[0]});
        checkOutput($sformatf("wide_vec%0d", idx), ifWide.out, v.exp);
        prevExp = v.exp;
    endtask

    initial begin
        vec_t rv;
        vec_t iv;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b00, 32'h0000_0000};
        vecs[1] = '{32'h0000_0001, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0000, 2'b01, 32'h8000_0001};
        vecs[2] = '{32'h0F0F_0F0E, 32'h1111_1111, 32'h2222_2222, 32'h3333_3332, 2'b10, 32'h2222_2222};
        vecs[3] = '{32'h4444_4444, 32'h5555_5554, 32'h6666_6667, 32'h7777_7777, 2'b11, 32'h7777_7777};
        vecs[4] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 32'hDEAD_BEEF};
        vecs[5] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 2'b01, 32'h1234_5678};
        vecs[6] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000};
        vecs[7] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFF};
        vecs[8] = '{32'hCAFE_F00D, 32'hABCD_0123, 32'h5A5A_A5A5, 32'h0BAD_BEE0, 2'b10, 32'h5A5A_A5A5};

        rv = '{32'h89AB_CDEF, 32'h89AB_CDEF, 32'h89AB_CDEF, 32'h89AB_CDEF, 2'b00, 32'h89AB_CDEF};

        // Reset asserted before any clock edge must clear the registered outputs at once
        #2;
        driveVector(rv);
        rst = 1'b1;
        #1;
        checkOutput("narrow_reset_async", {31'b0, ifNarrow.out}, 32'h0);
        checkOutput("wide_reset_async", ifWide.out, 32'h0);
        checkOutput("comb_ignores_reset", {31'b0, ifComb.out}, 32'h1);
        @(posedge clk);
        #1;
        checkOutput("narrow_reset_hold", {31'b0, ifNarrow.out}, 32'h0);
        checkOutput("wide_reset_hold", ifWide.out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("narrow_release_no_edge", {31'b0, ifNarrow.out}, 32'h0);
        checkOutput("wide_release_no_edge", ifWide.out, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("narrow_release_load", {31'b0, ifNarrow.out}, 32'h1);
        checkOutput("wide_release_load", ifWide.out, 32'h89AB_CDEF);
        prevExp = rv.exp;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Mid-operation reset pulse between edges while wide out is all-ones
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("wide_midreset_clear", ifWide.out, 32'h0);
        checkOutput("narrow_midreset_clear", {31'b0, ifNarrow.out}, 32'h0);
        checkOutput("comb_midreset_unaffected", {31'b0, ifComb.out}, 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("wide_midreset_released_no_edge", ifWide.out, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("wide_midreset_reload", ifWide.out, 32'hFFFF_FFFF);
        checkOutput("narrow_midreset_reload", {31'b0, ifNarrow.out}, 32'h1);

        // Changing only the unselected inputs must leave out untouched
        iv = '{32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFF};
        @(negedge clk);
        driveVector(iv);
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("wide_independence_edge%0d", e), ifWide.out, 32'hFFFF_FFFF);
            checkOutput($sformatf("narrow_independence_edge%0d", e), {31'b0, ifNarrow.out}, 32'h1);
            checkOutput($sformatf("comb_independence_edge%0d", e), {31'b0, ifComb.out}, 32'h1);
        end
        prevExp = 32'hFFFF_FFFF;

        // Simultaneous select and data change captured together on one edge
        applyStimulus(vecs[8], 8);

        // Combinational variant: select change with no clock edge, reset toggles ignored
        @(negedge clk);
        ifComb.in1  = 1'b0;
        ifComb.in2  = 1'b0;
        ifComb.in3  = 1'b0;
        ifComb.in4  = 1'b1;
        ifComb.sel1 = 1'b0;
        ifComb.sel0 = 1'b0;
        #1;
        checkOutput("comb_sel00", {31'b0, ifComb.out}, 32'h0);
        ifComb.sel1 = 1'b1;
        ifComb.sel0 = 1'b1;
        #1;
        checkOutput("comb_sel11_zero_latency", {31'b0, ifComb.out}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("comb_rst_high", {31'b0, ifComb.out}, 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("comb_rst_low", {31'b0, ifComb.out}, 32'h1);

        $display("[TB] stimulus complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
